// File: rtl/xyolo_read_stage_pkg.sv
// Shared constants for the xyolo read stage: vector width, address widths
// and the fetch FSM encodings.
package xyolo_read_stage_pkg;

    localparam int N_YOLO_VECT   = 4;
    localparam int IO_ADDR_W     = 32;
    localparam int WEIGHT_ADDR_W = 10;
    localparam int LANE_W        = $clog2(N_YOLO_VECT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BIAS   = 2'd1;
    localparam logic [1:0] ST_WEIGHT = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    // Picks the first fetch phase that actually has words to move.
    function automatic logic [1:0] fetchEntryState(input logic withBias, input logic haveWeights);
        if (withBias)
            return ST_BIAS;
        else if (haveWeights)
            return ST_WEIGHT;
        return ST_FLUSH;
    endfunction

endpackage

// File: rtl/xyolo_read_stage_mem.sv
// Simple two-port lane memory: one write port, one registered read port.
// A read and a write to the same address in one cycle returns the old word.
module xyolo_read_stage_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              r_en_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [DATA_W-1:0] r_data_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port stores the committed weight word.
    always_ff @(posedge clk) begin
        if (w_en_i)
            mem[w_addr_i] <= w_data_i;
    end

    // Read port registers the addressed word; it holds when not enabled.
    always_ff @(posedge clk) begin
        if (r_en_i)
            r_data_o <= mem[r_addr_i];
    end

endmodule

// File: rtl/xyolo_read_stage.sv
// Weight/bias load stage: fetches bias words then an interleaved weight block
// over a read-only databus master, stores them per lane, and serves them to
// the write stage through the shared read address generator.
module xyolo_read_stage
    import xyolo_read_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int W_ADDR_W = WEIGHT_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          global_run,
    output logic                          done,
    input  logic [IO_ADDR_W-1:0]          ext_addr,
    input  logic                          bias_en,
    input  logic [W_ADDR_W:0]             n_weights,
    input  logic                          weight_rd_en,
    input  logic [W_ADDR_W-1:0]           weight_rd_addr,
    input  logic                          databus_ready,
    output logic                          databus_valid,
    output logic [IO_ADDR_W-1:0]          databus_addr,
    input  logic [DATA_W-1:0]             databus_rdata,
    output logic [DATA_W-1:0]             databus_wdata,
    output logic [DATA_W/8-1:0]           databus_wstrb,
    output logic [N_YOLO_VECT*DATA_W-1:0] flow_out_weight,
    output logic [N_YOLO_VECT*DATA_W-1:0] flow_out_bias
);

    localparam int NW_W = W_ADDR_W + 1;
    localparam int VEC_W = N_YOLO_VECT * DATA_W;

    logic [1:0]           state_q, state_d;
    logic [IO_ADDR_W-1:0] wordIdx_q, wordIdx_d;
    logic [LANE_W-1:0]    laneIdx_q, laneIdx_d;
    logic [W_ADDR_W-1:0]  rowIdx_q, rowIdx_d;
    logic [IO_ADDR_W-1:0] extAddr_q;
    logic [NW_W-1:0]      nWeights_q;

    logic                 wrEn_q, wrEn_d;
    logic [W_ADDR_W-1:0]  wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0]    wrData_q, wrData_d;
    logic [LANE_W-1:0]    wrLane_q, wrLane_d;

    logic [DATA_W-1:0]    biasReg_q [N_YOLO_VECT];
    logic                 biasWe;
    logic                 rdEn_q;
    logic [VEC_W-1:0]     flowWeight_q, flowBias_q;
    logic [VEC_W-1:0]     weightPacked, biasPacked;
    logic [DATA_W-1:0]    laneRdata [N_YOLO_VECT];

    logic accept;
    logic lastLane;
    logic lastRow;

    assign databus_valid = (state_q == ST_BIAS) || (state_q == ST_WEIGHT);
    assign databus_addr  = extAddr_q + wordIdx_q;
    assign databus_wdata = '0;
    assign databus_wstrb = '0;
    assign accept        = databus_valid && databus_ready;
    assign lastLane      = (laneIdx_q == LANE_W'(N_YOLO_VECT - 1));
    assign lastRow       = (({1'b0, rowIdx_q} + NW_W'(1)) == nWeights_q);
    assign done          = (state_q == ST_IDLE) && !wrEn_q;

    assign flow_out_weight = flowWeight_q;
    assign flow_out_bias   = flowBias_q;

    // Fetch sequencing: word/lane/row counters advance per accepted word and a
    // new run always restarts from word 0 with freshly sampled configuration.
    always_comb begin
        state_d   = state_q;
        wordIdx_d = wordIdx_q;
        laneIdx_d = laneIdx_q;
        rowIdx_d  = rowIdx_q;
        wrEn_d    = 1'b0;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;
        wrLane_d  = wrLane_q;
        biasWe    = 1'b0;
        if (global_run) begin
            state_d   = fetchEntryState(bias_en, n_weights != '0);
            wordIdx_d = '0;
            laneIdx_d = '0;
            rowIdx_d  = '0;
        end else begin
            case (state_q)
                ST_BIAS: begin
                    if (accept) begin
                        wordIdx_d = wordIdx_q + IO_ADDR_W'(1);
                        biasWe    = 1'b1;
                        if (lastLane) begin
                            laneIdx_d = '0;
                            state_d   = fetchEntryState(1'b0, nWeights_q != '0);
                        end else begin
                            laneIdx_d = laneIdx_q + LANE_W'(1);
                        end
                    end
                end
                ST_WEIGHT: begin
                    if (accept) begin
                        wordIdx_d = wordIdx_q + IO_ADDR_W'(1);
                        wrEn_d    = 1'b1;
                        wrAddr_d  = rowIdx_q;
                        wrData_d  = databus_rdata;
                        wrLane_d  = laneIdx_q;
                        if (lastLane) begin
                            laneIdx_d = '0;
                            if (lastRow) begin
                                rowIdx_d = '0;
                                state_d  = ST_FLUSH;
                            end else begin
                                rowIdx_d = rowIdx_q + W_ADDR_W'(1);
                            end
                        end else begin
                            laneIdx_d = laneIdx_q + LANE_W'(1);
                        end
                    end
                end
                ST_FLUSH: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM, counters, sampled config and the one-deep registered write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wordIdx_q  <= '0;
            laneIdx_q  <= '0;
            rowIdx_q   <= '0;
            extAddr_q  <= '0;
            nWeights_q <= '0;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            wrLane_q   <= '0;
        end else begin
            state_q   <= state_d;
            wordIdx_q <= wordIdx_d;
            laneIdx_q <= laneIdx_d;
            rowIdx_q  <= rowIdx_d;
            wrEn_q    <= wrEn_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            wrLane_q  <= wrLane_d;
            if (global_run) begin
                extAddr_q  <= ext_addr;
                nWeights_q <= n_weights;
            end
        end
    end

    // Bias bank keeps old values until a bias word for that lane arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_YOLO_VECT; i++)
                biasReg_q[i] <= '0;
        end else if (biasWe) begin
            biasReg_q[laneIdx_q] <= databus_rdata;
        end
    end

    // Lane packing: lane 0 sits in the most significant word.
    always_comb begin
        weightPacked = '0;
        biasPacked   = '0;
        for (int i = 0; i < N_YOLO_VECT; i++) begin
            weightPacked[VEC_W-DATA_W*i-1 -: DATA_W] = laneRdata[i];
            biasPacked[VEC_W-DATA_W*i-1 -: DATA_W]   = biasReg_q[i];
        end
    end

    // Output registers: weights update only for an issued read, bias always.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdEn_q       <= 1'b0;
            flowWeight_q <= '0;
            flowBias_q   <= '0;
        end else begin
            rdEn_q     <= weight_rd_en;
            flowBias_q <= biasPacked;
            if (rdEn_q)
                flowWeight_q <= weightPacked;
        end
    end

    for (genvar g = 0; g < N_YOLO_VECT; g++) begin : g_lane
        xyolo_read_stage_mem #(
            .DATA_W (DATA_W),
            .ADDR_W (W_ADDR_W)
        ) u_mem (
            .clk      (clk),
            .w_en_i   (wrEn_q && (wrLane_q == LANE_W'(g))),
            .w_addr_i (wrAddr_q),
            .w_data_i (wrData_q),
            .r_en_i   (weight_rd_en),
            .r_addr_i (weight_rd_addr),
            .r_data_o (laneRdata[g])
        );
    end

endmodule

// File: tb/tb_xyolo_read_stage.sv
// Self-checking bench for xyolo_read_stage: a memory responder returning
// word k = k+1+offset, a fetch driver, and per-scenario checking tasks with a
// queue of expected read results.
module tb_xyolo_read_stage;
    import xyolo_read_stage_pkg::*;

    localparam int DW = 32;
    localparam int AW = WEIGHT_ADDR_W;
    localparam int VW = N_YOLO_VECT * DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 global_run;
    logic                 done;
    logic [IO_ADDR_W-1:0] ext_addr;
    logic                 bias_en;
    logic [AW:0]          n_weights;
    logic                 weight_rd_en;
    logic [AW-1:0]        weight_rd_addr;
    logic                 databus_ready;
    logic                 databus_valid;
    logic [IO_ADDR_W-1:0] databus_addr;
    logic [DW-1:0]        databus_rdata;
    logic [DW-1:0]        databus_wdata;
    logic [DW/8-1:0]      databus_wstrb;
    logic [VW-1:0]        flow_out_weight;
    logic [VW-1:0]        flow_out_bias;

    logic [31:0] extBase = 32'h0;
    logic [31:0] dataOff = 32'h0;
    logic [VW-1:0] expQ [$];

    int checks = 0;
    int failures = 0;

    xyolo_read_stage #(.DATA_W(DW), .W_ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .global_run      (global_run),
        .done            (done),
        .ext_addr        (ext_addr),
        .bias_en         (bias_en),
        .n_weights       (n_weights),
        .weight_rd_en    (weight_rd_en),
        .weight_rd_addr  (weight_rd_addr),
        .databus_ready   (databus_ready),
        .databus_valid   (databus_valid),
        .databus_addr    (databus_addr),
        .databus_rdata   (databus_rdata),
        .databus_wdata   (databus_wdata),
        .databus_wstrb   (databus_wstrb),
        .flow_out_weight (flow_out_weight),
        .flow_out_bias   (flow_out_bias)
    );

    // External memory: word k relative to the fetch base holds k+1+offset.
    assign databus_rdata = databus_addr - extBase + 32'd1 + dataOff;

    always #5 clk = ~clk;

    // Expected weight row: word k = 4+4r+lane, lane 0 in the top word.
    function automatic logic [VW-1:0] expRow(input int r, input int off);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N_YOLO_VECT; i++)
            v[VW-DW*i-1 -: DW] = 32'(off + N_YOLO_VECT + 1 + N_YOLO_VECT*r + i);
        return v;
    endfunction

    // Expected bias bank: bias words are the first N fetched words.
    function automatic logic [VW-1:0] expBias(input int off);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N_YOLO_VECT; i++)
            v[VW-DW*i-1 -: DW] = 32'(off + 1 + i);
        return v;
    endfunction

    // Fetch driver: pulses global_run, plays the slave (optionally stalling
    // every other valid cycle) and reports what it observed.
    task automatic runFetch(input logic [31:0] ext, input logic biasEn, input logic [AW:0] nW,
                            input bit toggle, input int abortAt,
                            output int validCycles, output int stallCycles,
                            output int addrBad, output int stallBad, output int doneDelay,
                            output logic doneAfterRun, output logic validAfterRun,
                            output bit timedOut);
        int cyc, accepted, lastEvent;
        logic [31:0] expAddr, heldAddr;
        bit stalledPrev, phase;
        validCycles = 0; stallCycles = 0; addrBad = 0; stallBad = 0; doneDelay = -1;
        doneAfterRun = 1'bx; validAfterRun = 1'bx; timedOut = 1;
        accepted = 0; lastEvent = 0; stalledPrev = 0; heldAddr = '0;
        @(negedge clk);
        ext_addr = ext; bias_en = biasEn; n_weights = nW; extBase = ext;
        global_run = 1'b1; databus_ready = 1'b0;
        cyc = 0; expAddr = ext; phase = toggle;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                global_run = 1'b0;
                doneAfterRun = done;
                validAfterRun = databus_valid;
            end
            if (stalledPrev && databus_addr !== heldAddr) stallBad++;
            stalledPrev = 0;
            if (databus_valid) begin
                validCycles++;
                if (toggle && phase) begin
                    databus_ready = 1'b0;
                    stallCycles++;
                    heldAddr = databus_addr;
                    stalledPrev = 1;
                end else begin
                    databus_ready = 1'b1;
                    if (databus_addr !== expAddr) addrBad++;
                    expAddr++;
                    accepted++;
                    lastEvent = cyc;
                end
                if (toggle) phase = !phase;
                if (abortAt > 0 && accepted == abortAt) begin
                    timedOut = 0;
                    break;
                end
            end else begin
                databus_ready = !toggle;
                if (done) begin
                    doneDelay = cyc - lastEvent;
                    timedOut = 0;
                    break;
                end
            end
        end
    endtask

    // Reset values straight out of reset.
    task automatic test_reset();
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL reset_done: got %b expected 1", done); end
        checks++; if (databus_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", databus_valid); end
        checks++; if (databus_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", databus_addr); end
        checks++; if (flow_out_weight !== '0) begin failures++; $display("[TB] FAIL reset_weight: got %h expected 0", flow_out_weight); end
        checks++; if (flow_out_bias !== '0) begin failures++; $display("[TB] FAIL reset_bias: got %h expected 0", flow_out_bias); end
        checks++; if (databus_wstrb !== '0 || databus_wdata !== '0) begin failures++; $display("[TB] FAIL reset_wr_tie: got %h/%h expected 0/0", databus_wstrb, databus_wdata); end
    endtask

    // Pipelined read-back of every row plus the bias bank through the scoreboard.
    task automatic test_readback(input string tag, input int nRows, input int wOff, input int bOff);
        logic [VW-1:0] exp;
        for (int i = 0; i < nRows + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                exp = expQ.pop_front();
                checks++;
                if (flow_out_weight !== exp) begin
                    failures++;
                    $display("[TB] FAIL %s_row%0d: got %h expected %h", tag, i - 2, flow_out_weight, exp);
                end
            end
            if (i < nRows) begin
                weight_rd_en = 1'b1;
                weight_rd_addr = AW'(i);
                expQ.push_back(expRow(i, wOff));
            end else begin
                weight_rd_en = 1'b0;
            end
        end
        checks++;
        if (flow_out_bias !== expBias(bOff)) begin
            failures++;
            $display("[TB] FAIL %s_bias: got %h expected %h", tag, flow_out_bias, expBias(bOff));
        end
    endtask

    // Uninterrupted fetch with ready held high.
    task automatic test_basic_fetch();
        int vc, sc, ab, sb, dd; logic dar, var_; bit to;
        dataOff = 0;
        runFetch(32'h100, 1'b1, 11'd2, 0, 0, vc, sc, ab, sb, dd, dar, var_, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL basic_timeout: fetch did not finish"); end
        checks++; if (dar !== 1'b0 || var_ !== 1'b1) begin failures++; $display("[TB] FAIL basic_run_edge: got done=%b valid=%b expected 0/1", dar, var_); end
        checks++; if (vc != 12) begin failures++; $display("[TB] FAIL basic_cycles: got %0d expected 12", vc); end
        checks++; if (ab != 0) begin failures++; $display("[TB] FAIL basic_addr: got %0d bad addresses expected 0", ab); end
        checks++; if (dd != 2) begin failures++; $display("[TB] FAIL basic_done_delay: got %0d expected 2", dd); end
        test_readback("basic", 2, 0, 0);
    endtask

    // Read latency of two cycles and hold while weight_rd_en is low.
    task automatic test_read_latency();
        int holdBad;
        logic [VW-1:0] exp;
        holdBad = 0;
        @(negedge clk); weight_rd_en = 1'b1; weight_rd_addr = '0;
        @(negedge clk); weight_rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk); weight_rd_en = 1'b1; weight_rd_addr = AW'(1);
        expQ.push_back(expRow(1, 0));
        @(negedge clk); weight_rd_en = 1'b0; weight_rd_addr = '0;
        checks++; if (flow_out_weight !== expRow(0, 0)) begin failures++; $display("[TB] FAIL lat_t1: got %h expected %h", flow_out_weight, expRow(0, 0)); end
        @(negedge clk);
        exp = expQ.pop_front();
        checks++; if (flow_out_weight !== exp) begin failures++; $display("[TB] FAIL lat_t2: got %h expected %h", flow_out_weight, exp); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (flow_out_weight !== exp) holdBad++;
        end
        checks++; if (holdBad != 0) begin failures++; $display("[TB] FAIL lat_hold: got %0d changed cycles expected 0", holdBad); end
    endtask

    // Ready toggling every other cycle: stalls hold the address steady.
    task automatic test_stall_fetch();
        int vc, sc, ab, sb, dd; logic dar, var_; bit to;
        dataOff = 100;
        runFetch(32'h100, 1'b1, 11'd2, 1, 0, vc, sc, ab, sb, dd, dar, var_, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL stall_timeout: fetch did not finish"); end
        checks++; if (vc != 24) begin failures++; $display("[TB] FAIL stall_cycles: got %0d expected 24", vc); end
        checks++; if (sc != 12) begin failures++; $display("[TB] FAIL stall_count: got %0d expected 12", sc); end
        checks++; if (ab != 0 || sb != 0) begin failures++; $display("[TB] FAIL stall_addr: got %0d/%0d bad expected 0/0", ab, sb); end
        checks++; if (dd != 2) begin failures++; $display("[TB] FAIL stall_done_delay: got %0d expected 2", dd); end
        test_readback("stall", 2, 100, 100);
    endtask

    // Nothing to fetch: no requests, a short done dip, bias untouched.
    task automatic test_empty_run();
        int vc, sc, ab, sb, dd; logic dar, var_; bit to;
        dataOff = 0;
        runFetch(32'h300, 1'b0, 11'd0, 0, 0, vc, sc, ab, sb, dd, dar, var_, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL empty_timeout: done never returned"); end
        checks++; if (vc != 0) begin failures++; $display("[TB] FAIL empty_valid: got %0d valid cycles expected 0", vc); end
        checks++; if (dar !== 1'b0) begin failures++; $display("[TB] FAIL empty_done_fall: got %b expected 0", dar); end
        checks++; if (dd != 2) begin failures++; $display("[TB] FAIL empty_done_delay: got %0d expected 2", dd); end
        @(negedge clk);
        checks++; if (flow_out_bias !== expBias(100)) begin failures++; $display("[TB] FAIL empty_bias: got %h expected %h", flow_out_bias, expBias(100)); end
    endtask

    // Restart after five accepted words; result must equal a clean fetch.
    task automatic test_abort_restart();
        int vc, sc, ab, sb, dd; logic dar, var_; bit to;
        dataOff = 0;
        runFetch(32'h100, 1'b1, 11'd2, 0, 5, vc, sc, ab, sb, dd, dar, var_, to);
        checks++; if (ab != 0) begin failures++; $display("[TB] FAIL abort_first_addr: got %0d bad expected 0", ab); end
        runFetch(32'h100, 1'b1, 11'd2, 0, 0, vc, sc, ab, sb, dd, dar, var_, to);
        checks++; if (to) begin failures++; $display("[TB] FAIL abort_timeout: fetch did not finish"); end
        checks++; if (ab != 0 || vc != 12) begin failures++; $display("[TB] FAIL abort_restart: got bad=%0d cycles=%0d expected 0/12", ab, vc); end
        test_readback("abort", 2, 0, 0);
    endtask

    // Asynchronous reset in the middle of the weight phase.
    task automatic test_reset_mid_weight();
        int vc, sc, ab, sb, dd; logic dar, var_; bit to;
        runFetch(32'h100, 1'b1, 11'd2, 0, 6, vc, sc, ab, sb, dd, dar, var_, to);
        #2 rst = 1'b1;
        #1;
        checks++; if (databus_valid !== 1'b0 || done !== 1'b1) begin failures++; $display("[TB] FAIL midrst_ctrl: got valid=%b done=%b expected 0/1", databus_valid, done); end
        checks++; if (flow_out_weight !== '0 || flow_out_bias !== '0 || databus_addr !== '0) begin failures++; $display("[TB] FAIL midrst_data: got w=%h b=%h a=%h expected zeros", flow_out_weight, flow_out_bias, databus_addr); end
        databus_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++; if (databus_valid !== 1'b0 || done !== 1'b1) begin failures++; $display("[TB] FAIL midrst_after: got valid=%b done=%b expected 0/1", databus_valid, done); end
    endtask

    // Scenario sequence.
    initial begin
        rst = 1'b1; global_run = 1'b0; ext_addr = '0; bias_en = 1'b0; n_weights = '0;
        weight_rd_en = 1'b0; weight_rd_addr = '0; databus_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_read_latency();
        test_stall_fetch();
        test_empty_run();
        test_abort_restart();
        test_reset_mid_weight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
